// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

  localparam int unsigned BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } b2b_state_t;

  localparam bcd_digit_t BCD_NINE = 4'd9;

  // Shift-and-add-3 correction: a digit of 5..9 would exceed 9 after doubling.
  function automatic bcd_digit_t bcd_add3(input bcd_digit_t d);
    return (d >= 4'd5) ? bcd_digit_t'(d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/done handshake bundle for bin_to_bcd_seq.
// Optional blank_mask signal is present only when BIN2BCD_BLANK_EN is defined.
interface bin_to_bcd_seq_if #(
  parameter int unsigned WIDTH  = 14,
  parameter int unsigned DIGITS = 4
) ();

  logic                  start;
  logic [WIDTH-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;
`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0]     blank_mask;

  modport master (output start, bin_in,
                  input  busy, done, bcd_out, overflow, blank_mask);
  modport slave  (input  start, bin_in,
                  output busy, done, bcd_out, overflow, blank_mask);
`else
  modport master (output start, bin_in,
                  input  busy, done, bcd_out, overflow);
  modport slave  (input  start, bin_in,
                  output busy, done, bcd_out, overflow);
`endif

endinterface

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// Combinational add-3 correction for one BCD scratch digit.
module bin_to_bcd_seq_digit_adj
  import bin_to_bcd_seq_pkg::*;
(
  input  bcd_digit_t i_digit,
  output bcd_digit_t o_digit_c
);

  assign o_digit_c = bcd_add3(i_digit);

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one shift-and-add-3 step per clock.
// Optional leading-zero mask output enabled by BIN2BCD_BLANK_EN.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = 14,
  parameter int unsigned DIGITS = 4
) (
  input  logic            clk,
  input  logic            reset,
  bin_to_bcd_seq_if.slave bus
);

  localparam int unsigned SD = (WIDTH + 2) / 3;
  localparam int unsigned SW = BCD_W * SD;
  localparam int unsigned OW = BCD_W * DIGITS;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  b2b_state_t       r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [SW-1:0]    r_scratch;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [OW-1:0]    r_bcd;
  logic             r_ovf;

  logic [SW-1:0]    w_adj;
  logic [SW-1:0]    w_scratch_nxt;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic [OW-1:0]    w_low;
  logic             w_ovf;
  logic [OW-1:0]    w_bcd_sat;

  // Per-digit add-3 correction on the current scratch value
  for (genvar g = 0; g < SD; g++) begin : g_adj
    bin_to_bcd_seq_digit_adj u_adj (
      .i_digit   (r_scratch[BCD_W*g +: BCD_W]),
      .o_digit_c (w_adj[BCD_W*g +: BCD_W])
    );
  end

  // Corrected scratch and shift register shifted left by one as a single chain
  assign w_scratch_nxt = {w_adj[SW-2:0], r_shreg[WIDTH-1]};
  assign w_shreg_nxt   = {r_shreg[WIDTH-2:0], 1'b0};

  // Split the scratch result into displayed digits and overflow digits
  if (SD > DIGITS) begin : g_ovf
    assign w_low = w_scratch_nxt[OW-1:0];
    assign w_ovf = |w_scratch_nxt[SW-1:OW];
  end else begin : g_no_ovf
    assign w_low = OW'(w_scratch_nxt);
    assign w_ovf = 1'b0;
  end

  assign w_bcd_sat = w_ovf ? {DIGITS{BCD_NINE}} : w_low;

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] r_blank;
  logic [DIGITS-1:0] w_blank;

  // Digit i is significant when it or any higher digit is nonzero
  always_comb begin
    logic acc;
    acc     = 1'b0;
    w_blank = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      acc        = acc | (w_low[BCD_W*i +: BCD_W] != 4'd0);
      w_blank[i] = acc;
    end
    w_blank[0] = 1'b1;
    if (w_ovf) begin
      w_blank = '1;
    end
  end

  assign bus.blank_mask = r_blank;
`endif

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_shreg   <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_bcd     <= '0;
      r_ovf     <= 1'b0;
`ifdef BIN2BCD_BLANK_EN
      r_blank   <= DIGITS'(1);
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_shreg   <= bus.bin_in;
            r_scratch <= '0;
            r_cnt     <= CW'(WIDTH);
            r_busy    <= 1'b1;
            r_state   <= SHIFT;
          end
        end
        SHIFT: begin
          r_shreg   <= w_shreg_nxt;
          r_scratch <= w_scratch_nxt;
          r_cnt     <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_bcd   <= w_bcd_sat;
            r_ovf   <= w_ovf;
`ifdef BIN2BCD_BLANK_EN
            r_blank <= w_blank;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.bcd_out  = r_bcd;
  assign bus.overflow = r_ovf;

endmodule
